// File: rtl/vr_loc_emu.sv
// Digital potentiometer emulator: returns the comparator-style wiper bit of a pot whose position slews toward a written target.
// Optional noise injection is enabled by defining VR_LOC_EMU_NOISE_EN.
module vr_loc_emu #(
  parameter int C_DLY      = 2,
  parameter int C_SLEW_DIV = 1024,
  parameter int C_NOISE_SH = 6
) (
  input  logic       CK_i,
  input  logic       XARST_i,
  input  tri1        EN_CK_i,
  input  logic       TPAT_P_i,
  input  logic       TPAT_N_i,
  input  logic [7:0] LOC_i,
  input  logic       LOC_WR_i,
  output logic       DAT_o,
  output logic [7:0] CUR_LOC_o,
  output logic       MOVING_o
);

  localparam int DIV_W = (C_SLEW_DIV > 1) ? $clog2(C_SLEW_DIV) : 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(C_SLEW_DIV - 1);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_MOVING = 1'b1
  } state_t;

  logic             p_r;
  logic             n_r;
  logic             d_r;
  logic [7:0]       acc_r;
  logic [7:0]       cur_r;
  logic [7:0]       tgt_r;
  logic [DIV_W-1:0] div_r;
  logic [C_DLY:0]   pipe_r;
  state_t           state_r;

  logic [8:0]       sum_s;
  logic             d_s;
  logic             flip_s;
  logic [7:0]       step_s;
  logic [7:0]       next_tgt_s;

`ifdef VR_LOC_EMU_NOISE_EN
  logic [31:0] lfsr_r;

  // Galois LFSR for x^32+x^22+x^2+x+1, shifting right
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      lfsr_r <= 32'h1234_5678;
    end else if (EN_CK_i) begin
      lfsr_r <= {1'b0, lfsr_r[31:1]} ^ (lfsr_r[0] ? 32'h8020_0003 : 32'h0000_0000);
    end
  end

  assign flip_s = &lfsr_r[C_NOISE_SH-1:0];
`else
  assign flip_s = 1'b0;
`endif

  // Sigma-delta style decision: a mismatch picks P on carry, so CUR/256 of mismatch cycles select P
  always_comb begin
    sum_s = {1'b0, acc_r} + {1'b0, cur_r};
    if (p_r == n_r) begin
      d_s = p_r;
    end else if (sum_s[8]) begin
      d_s = p_r;
    end else begin
      d_s = n_r;
    end
  end

  // One-LSB step toward the target and the target the IDLE state would act on this cycle
  always_comb begin
    if (cur_r < tgt_r) begin
      step_s = cur_r + 8'd1;
    end else begin
      step_s = cur_r - 8'd1;
    end
    if (LOC_WR_i) begin
      next_tgt_s = LOC_i;
    end else begin
      next_tgt_s = tgt_r;
    end
  end

  // Input sampling, accumulator, decision register and latency pipeline
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      p_r    <= 1'b0;
      n_r    <= 1'b0;
      acc_r  <= 8'h00;
      d_r    <= 1'b0;
      pipe_r <= '0;
    end else if (EN_CK_i) begin
      p_r <= TPAT_P_i;
      n_r <= TPAT_N_i;
      if (p_r != n_r) begin
        acc_r <= sum_s[7:0];
      end
      d_r       <= d_s ^ flip_s;
      pipe_r[0] <= d_r;
      for (int i = 1; i <= C_DLY; i++) begin
        pipe_r[i] <= pipe_r[i-1];
      end
    end
  end

  // Target register: writes land even while the clock enable is low
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      tgt_r <= 8'h80;
    end else if (LOC_WR_i) begin
      tgt_r <= LOC_i;
    end
  end

  // Slew FSM; a step coinciding with a write uses the old target and defers the IDLE decision a cycle
  always_ff @(posedge CK_i or negedge XARST_i) begin
    if (!XARST_i) begin
      state_r <= ST_IDLE;
      cur_r   <= 8'h80;
      div_r   <= '0;
    end else if (EN_CK_i) begin
      case (state_r)
        ST_IDLE: begin
          if (next_tgt_s != cur_r) begin
            state_r <= ST_MOVING;
            div_r   <= '0;
          end
        end
        ST_MOVING: begin
          if (cur_r == tgt_r) begin
            if (!LOC_WR_i) begin
              state_r <= ST_IDLE;
              div_r   <= '0;
            end
          end else if (div_r == DIV_LAST) begin
            cur_r <= step_s;
            div_r <= '0;
            if (!LOC_WR_i && (step_s == tgt_r)) begin
              state_r <= ST_IDLE;
            end
          end else begin
            div_r <= div_r + DIV_W'(1);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          div_r   <= '0;
        end
      endcase
    end
  end

  assign DAT_o     = pipe_r[C_DLY];
  assign CUR_LOC_o = cur_r;
  assign MOVING_o  = (state_r == ST_MOVING);

endmodule
